alib_point_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one point FIFO write port (16-bit h/v/r point triplet plus write enable and full) among NUM_REQ point producers in the range-image pipeline. Each producer streams points over a valid/ready handshake in bursts. The arbiter locks onto one producer per burst, forwards accepted points combinationally into the FIFO, and applies FIFO-full backpressure to the granted producer only.

---
 rtl/alib_point_write_arbiter.sv | 133 +++++++++++++
 tb/tb_alib_point_write_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alib_point_write_arbiter.sv
// Round-robin burst arbiter sharing one point-FIFO write port among NUM_REQ producers.
// Build-time option: define ALIB_ARB_STATS_EN to build the accept/stall statistics counters.
module alib_point_write_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*16-1:0]        req_h,
  input  logic [NUM_REQ*16-1:0]        req_v,
  input  logic [NUM_REQ*16-1:0]        req_r,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full,
  output logic                         fifo_wr_en,
  output logic [15:0]                  fifo_point_h,
  output logic [15:0]                  fifo_point_v,
  output logic [15:0]                  fifo_point_r,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic [NUM_REQ*32-1:0]        accept_cnt,
  output logic [31:0]                  stall_cnt
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] grant_q, grant_d;
  logic [IdW-1:0] last_q, last_d;
  logic [7:0]     burst_q, burst_d;

  logic           rr_found;
  logic [IdW-1:0] rr_idx;
  logic [IdW-1:0] cand;
  logic           grant_valid;
  logic           grant_last;
  logic           xfer;

  // Search starts one past the previous grant and wraps.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdW'((32'(last_q) + k) % NUM_REQ);
      if (!rr_found && req_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign grant_valid = req_valid[grant_q];
  assign grant_last  = req_last[grant_q];
  assign xfer        = (state_q == StGrant) && grant_valid && !fifo_full;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    burst_d   = burst_q;
    req_ready = '0;
    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          grant_d = rr_idx;
          burst_d = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        req_ready[grant_q] = !fifo_full;
        if (xfer) burst_d = burst_q + 8'd1;
        if (!grant_valid || (xfer && (grant_last || burst_d == 8'(BURST_MAX)))) begin
          state_d = StIdle;
          last_d  = grant_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdW'(NUM_REQ - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  assign fifo_wr_en   = xfer;
  assign busy         = (state_q == StGrant);
  assign grant_id     = grant_q;
  assign fifo_point_h = req_h[{grant_q, 4'b0000} +: 16];
  assign fifo_point_v = req_v[{grant_q, 4'b0000} +: 16];
  assign fifo_point_r = req_r[{grant_q, 4'b0000} +: 16];

`ifdef ALIB_ARB_STATS_EN
  logic [31:0] acc_q [NUM_REQ];
  logic [31:0] stall_q;

  // Counters saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) acc_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer && grant_q == IdW'(i) && acc_q[i] != '1) acc_q[i] <= acc_q[i] + 32'd1;
      end
      if (busy && grant_valid && fifo_full && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  always_comb begin
    accept_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) accept_cnt[32*i +: 32] = acc_q[i];
  end
  assign stall_cnt = stall_q;
`else
  assign accept_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_alib_point_write_arbiter.sv
// Bench for alib_point_write_arbiter: directed bursts plus randomized traffic against a
// behavioural arbitration model, with per-cycle output comparison.
module tb_alib_point_write_arbiter;

  localparam int N  = 4;
  localparam int BM = 8;
  localparam int IW = 2;
`ifdef ALIB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*16-1:0] req_h, req_v, req_r;
  logic            fifo_full, fifo_wr_en;
  logic [15:0]     ph, pv, pr;
  logic [IW-1:0]   grant_id;
  logic            busy;
  logic [N*32-1:0] accept_cnt;
  logic [31:0]     stall_cnt;

  alib_point_write_arbiter #(.NUM_REQ(N), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_h(req_h), .req_v(req_v), .req_r(req_r), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_point_h(ph), .fifo_point_v(pv), .fifo_point_r(pr),
    .grant_id(grant_id), .busy(busy), .accept_cnt(accept_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: who holds the port, how many points taken, statistics.
  bit     m_busy;
  int     m_gid, m_last, m_cnt;
  longint m_acc [N];
  longint m_stall;

  function automatic void model_reset();
    m_busy = 0; m_gid = 0; m_last = N - 1; m_cnt = 0; m_stall = 0;
    for (int i = 0; i < N; i++) m_acc[i] = 0;
  endfunction

  function automatic void model_step();
    bit xf;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        if (req_valid[(m_last + k) % N]) begin
          m_gid = (m_last + k) % N; m_busy = 1; m_cnt = 0;
          break;
        end
      end
    end else begin
      xf = req_valid[m_gid] && !fifo_full;
      if (xf) begin m_cnt++; m_acc[m_gid]++; end
      if (req_valid[m_gid] && fifo_full) m_stall++;
      if (!req_valid[m_gid] || (xf && (req_last[m_gid] || m_cnt == BM))) begin
        m_busy = 0; m_last = m_gid;
      end
    end
  endfunction

  logic [N-1:0] hs = '0;
  int           wr_cnt = 0;
  bit           prev_busy = 0;
  int           glog[$];

  initial begin : cmp_proc
    logic [N-1:0] exp_ready;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      exp_ready = '0;
      if (m_busy && !fifo_full) exp_ready[m_gid] = 1'b1;
      chk("req_ready", req_ready, exp_ready);
      chk("fifo_wr_en", fifo_wr_en, m_busy && req_valid[m_gid] && !fifo_full);
      chk("busy", busy, m_busy);
      chk("grant_id", grant_id, m_gid);
      chk("point_h", ph, req_h[16*m_gid +: 16]);
      chk("point_v", pv, req_v[16*m_gid +: 16]);
      chk("point_r", pr, req_r[16*m_gid +: 16]);
      for (int i = 0; i < N; i++) chk("accept_cnt", accept_cnt[32*i +: 32], STATS ? m_acc[i] : 0);
      chk("stall_cnt", stall_cnt, STATS ? m_stall : 0);
      hs = req_valid & req_ready;
      if (fifo_wr_en) wr_cnt++;
      if (busy && !prev_busy) glog.push_back(int'(grant_id));
      prev_busy = busy;
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Stimulus: each requester streams rem[i] points, optionally marking the final one last.
  int rem [N];
  bit use_last [N];
  bit rnd = 0;

  task automatic new_data(input int i);
    req_h[16*i +: 16] = 16'($urandom);
    req_v[16*i +: 16] = 16'($urandom);
    req_r[16*i +: 16] = 16'($urandom);
  endtask

  task automatic drive_req(input int i);
    req_valid[i] = rem[i] > 0;
    req_last[i]  = use_last[i] && rem[i] == 1;
    new_data(i);
  endtask

  task automatic set_stream(input int i, input int n, input bit l);
    rem[i] = n; use_last[i] = l; drive_req(i);
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (rnd) begin
        if (!(req_valid[i] && !hs[i])) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_last[i]  = ($urandom_range(0, 3) == 0);
          new_data(i);
        end
      end else if (hs[i]) begin
        rem[i]--;
        drive_req(i);
      end
    end
    if (rnd) fifo_full = ($urandom_range(0, 3) == 0);
  endtask

  task automatic start();
    rst = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) set_stream(i, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    glog.delete();
  endtask

  function automatic int glog_at(input int k);
    return (glog.size() > k) ? glog[k] : -1;
  endfunction

  initial begin : stim
    int w0;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    req_valid = '0; req_last = '0; fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; use_last[i] = 0; new_data(i); end
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_point", ph, req_h[15:0]);

    // Requester 2: three points, last on the third.
    start();
    w0 = wr_cnt;
    set_stream(2, 3, 1);
    #1 chk("t1_ready_idle", req_ready, 0);
    step();
    chk("t1_ready", req_ready, 4'b0100);
    repeat (3) step();
    chk("t1_writes", wr_cnt - w0, 3);
    chk("t1_grant", glog_at(0), 2);
    chk("t1_busy_after", busy, 0);

    // All four continuously valid: 0,1,2,3,0 with 8 writes each and one idle between.
    start();
    w0 = wr_cnt;
    for (int i = 0; i < N; i++) set_stream(i, 100, 0);
    repeat (45) step();
    chk("t2_ngrants", glog.size(), 5);
    for (int k = 0; k < 5; k++) chk("t2_seq", glog_at(k), exp_seq[k]);
    chk("t2_writes", wr_cnt - w0, 40);

    // Requester 1 stalled by FIFO full for five cycles mid-burst.
    start();
    w0 = wr_cnt;
    set_stream(1, 6, 1);
    repeat (3) step();
    fifo_full = 1'b1;
    repeat (5) step();
    chk("t3_no_writes", wr_cnt - w0, 2);
    chk("t3_busy_held", busy, 1);
    chk("t3_grant_held", grant_id, 1);
    fifo_full = 1'b0;
    repeat (6) step();
    chk("t3_writes", wr_cnt - w0, 6);
    chk("t3_stall", stall_cnt, STATS ? 5 : 0);

    // Requester 0 abandons after two points; requester 3 gets the next grant.
    start();
    set_stream(0, 2, 0);
    set_stream(3, 3, 1);
    repeat (9) step();
    chk("t4_ngrants", glog.size(), 2);
    chk("t4_first", glog_at(0), 0);
    chk("t4_second", glog_at(1), 3);

    // Reset mid-burst on requester 2; search restarts at requester 0.
    start();
    set_stream(2, 10, 0);
    repeat (3) step();
    chk("t5_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_ready", req_ready, 0);
    chk("t5_wr", fifo_wr_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_grant", grant_id, 0);
    chk("t5_point", ph, req_h[15:0]);
    @(posedge clk); #1;
    rst = 1'b0;
    glog.delete();
    for (int i = 0; i < N; i++) set_stream(i, 3, 1);
    repeat (2) step();
    chk("t5_next_grant", glog_at(0), 0);

    // Twenty points from requester 1 across three bursts.
    start();
    w0 = wr_cnt;
    set_stream(1, 20, 0);
    repeat (30) step();
    chk("t6_writes", wr_cnt - w0, 20);
    chk("t6_acc1", accept_cnt[63:32], STATS ? 20 : 0);
    chk("t6_acc0", accept_cnt[31:0], 0);
    chk("t6_ngrants", glog.size(), 3);

    // Randomized traffic with random FIFO backpressure.
    start();
    rnd = 1;
    repeat (3000) step();
    rnd = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
